// File: rtl/run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// run_ctrl_pkg
// Shared types and defaults for the run controller.
//   state_e        : controller states (HOLD, RELEASE, RUN, DONE, TIMEOUT)
//   DEF_*          : default parameter values used by run_ctrl, its watchdog
//                    sub-module and its bus interface
//   cnt_w()        : width of a down/up counter that must hold 0..n-1
// -----------------------------------------------------------------------------
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  localparam int          DEF_N_DOM      = 2;
  localparam int          DEF_HOLD       = 25;
  localparam int          DEF_STAGGER    = 4;
  localparam int          DEF_CYC_W      = 32;
  localparam int unsigned DEF_MAX_CYCLES = 30000000;

  // Smallest width able to represent every value 0..n-1 (never below 1 bit).
  function automatic int cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// -----------------------------------------------------------------------------
// run_ctrl_if
// Control/status bus of the run controller.
//   ext_rst_req   : restart request (driven by master)
//   pause_in      : stall request (driven by master)
//   halt_in       : program-complete strobe (driven by master)
//   dom_rst_out   : per-domain active-high resets (driven by slave)
//   rdy_out       : running and not paused (driven by slave)
//   done_out      : sticky normal completion (driven by slave)
//   timeout_out   : sticky watchdog expiry (driven by slave)
//   cycle_cnt_out : count of cycles with rdy_out high (driven by slave)
// The slave modport is used by run_ctrl; the master modport by whoever
// supervises it.
// -----------------------------------------------------------------------------
interface run_ctrl_if
  import run_ctrl_pkg::*;
#(
  parameter int N_DOM = DEF_N_DOM,
  parameter int CYC_W = DEF_CYC_W
);

  logic             ext_rst_req;
  logic             pause_in;
  logic             halt_in;
  logic [N_DOM-1:0] dom_rst_out;
  logic             rdy_out;
  logic             done_out;
  logic             timeout_out;
  logic [CYC_W-1:0] cycle_cnt_out;

  modport master (
    output ext_rst_req,
    output pause_in,
    output halt_in,
    input  dom_rst_out,
    input  rdy_out,
    input  done_out,
    input  timeout_out,
    input  cycle_cnt_out
  );

  modport slave (
    input  ext_rst_req,
    input  pause_in,
    input  halt_in,
    output dom_rst_out,
    output rdy_out,
    output done_out,
    output timeout_out,
    output cycle_cnt_out
  );

endinterface

// File: rtl/run_ctrl_wdog.sv
// -----------------------------------------------------------------------------
// run_ctrl_wdog
// Saturating run-cycle counter with watchdog comparator.
//   clk_in : clock
//   clear  : synchronous clear of the counter (restart or system reset)
//   en     : count this cycle (the controller's rdy_out)
//   limit  : watchdog limit in counted cycles, 0 disables expiry
//   count  : current count, saturates at all-ones
//   expire : high on the cycle whose increment reaches limit
// -----------------------------------------------------------------------------
module run_ctrl_wdog
  import run_ctrl_pkg::*;
#(
  parameter int CYC_W = DEF_CYC_W
) (
  input  logic             clk_in,
  input  logic             clear,
  input  logic             en,
  input  logic [CYC_W-1:0] limit,
  output logic [CYC_W-1:0] count,
  output logic             expire
);

  logic [CYC_W-1:0] r_count;
  logic             w_at_last;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + CYC_W'(1);
  endfunction

  always_ff @(posedge clk_in) begin
    if (clear) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= sat_inc(r_count);
    end
  end

  // Expiry is flagged on the incrementing cycle so the controller leaves RUN
  // on the same edge that the count lands on the limit.
  assign w_at_last = (r_count == (limit - CYC_W'(1)));
  assign expire    = en && (limit != '0) && w_at_last;
  assign count     = r_count;

endmodule

// File: rtl/run_ctrl.sv
// -----------------------------------------------------------------------------
// run_ctrl
// Power-on / restart sequencer for a multi-domain system:
//   HOLD     all domains held in reset for HOLD cycles
//   RELEASE  domain i released STAGGER cycles after domain i-1
//   RUN      rdy_out follows ~pause_in (one cycle late), cycles are counted
//   DONE     sticky, entered on halt_in
//   TIMEOUT  sticky, entered when the run count reaches MAX_CYCLES
// Ports:
//   clk_in  : clock, rising edge
//   rst_in  : synchronous active-low reset
//   bus     : run_ctrl_if.slave (ext_rst_req, pause_in, halt_in in;
//             dom_rst_out, rdy_out, done_out, timeout_out, cycle_cnt_out out)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int          N_DOM      = DEF_N_DOM,
  parameter int          HOLD       = DEF_HOLD,
  parameter int          STAGGER    = DEF_STAGGER,
  parameter int          CYC_W      = DEF_CYC_W,
  parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic         clk_in,
  input  logic         rst_in,
  run_ctrl_if.slave    bus
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (N_DOM < 1 || N_DOM > 8) begin : g_bad_n_dom
    $error("run_ctrl: N_DOM must be in 1..8");
  end
  if (HOLD < 1) begin : g_bad_hold
    $error("run_ctrl: HOLD must be at least 1");
  end
  if (STAGGER < 1) begin : g_bad_stagger
    $error("run_ctrl: STAGGER must be at least 1");
  end
  if (CYC_W < 1) begin : g_bad_cyc_w
    $error("run_ctrl: CYC_W must be at least 1");
  end
  if (CYC_W < 32 &&
      longint'(MAX_CYCLES) > ((longint'(1) << CYC_W) - longint'(1))) begin : g_bad_max
    $error("run_ctrl: MAX_CYCLES does not fit in CYC_W bits");
  end

  localparam int               HW        = cnt_w(HOLD);
  localparam int               SW        = cnt_w(STAGGER);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);
  localparam logic [SW-1:0]    STAG_LAST = SW'(STAGGER - 1);
  // Pattern left in r_dom_rst when only the last domain is still in reset.
  localparam logic [N_DOM-1:0] DOM_LAST  = N_DOM'(1) << (N_DOM - 1);
  localparam logic [CYC_W-1:0] LIMIT     = CYC_W'(MAX_CYCLES);

  state_e           r_state;
  logic [HW-1:0]    r_hold_cnt;
  logic [SW-1:0]    r_stag_cnt;
  logic [N_DOM-1:0] r_dom_rst;
  logic             r_rdy;
  logic             r_done;
  logic             r_tmo;

  logic             w_clear;
  logic             w_expire;
  logic [CYC_W-1:0] w_count;

  // System reset and restart request clear the counter identically.
  assign w_clear = ~rst_in | bus.ext_rst_req;

  run_ctrl_wdog #(
    .CYC_W (CYC_W)
  ) u_wdog (
    .clk_in (clk_in),
    .clear  (w_clear),
    .en     (r_rdy),
    .limit  (LIMIT),
    .count  (w_count),
    .expire (w_expire)
  );

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!rst_in || bus.ext_rst_req) begin
      r_state    <= ST_HOLD;
      r_hold_cnt <= '0;
      r_stag_cnt <= '0;
      r_dom_rst  <= '1;
      r_rdy      <= 1'b0;
      r_done     <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= ST_RELEASE;
            r_stag_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end

        ST_RELEASE: begin
          // Domains are released lowest first by shifting a zero into the
          // reset vector; the stagger counter spaces the shifts.
          if (r_stag_cnt == '0) begin
            r_dom_rst <= r_dom_rst << 1;
            if (r_dom_rst == DOM_LAST) begin
              r_state <= ST_RUN;
            end else begin
              r_stag_cnt <= STAG_LAST;
            end
          end else begin
            r_stag_cnt <= r_stag_cnt - SW'(1);
          end
        end

        ST_RUN: begin
          // Halt has priority so done and timeout can never both be set.
          if (bus.halt_in) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_rdy   <= 1'b0;
          end else if (w_expire) begin
            r_state <= ST_TIMEOUT;
            r_tmo   <= 1'b1;
            r_rdy   <= 1'b0;
          end else begin
            r_rdy <= ~bus.pause_in;
          end
        end

        ST_DONE, ST_TIMEOUT: begin
          r_rdy <= 1'b0;
        end

        default: begin
          r_state <= ST_HOLD;
          r_rdy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dom_rst_out   = r_dom_rst;
  assign bus.rdy_out       = r_rdy;
  assign bus.done_out      = r_done;
  assign bus.timeout_out   = r_tmo;
  assign bus.cycle_cnt_out = w_count;

endmodule

// File: tb/tb_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_run_ctrl
// Three run_ctrl instances with different parameter sets share one stimulus
// stream. Each is tracked by a timeline model: domain i is in reset while the
// cycle index c since restart is below HOLD+i*STAGGER, the run starts after the
// last release, and the run rules (pause, halt, watchdog, saturation) are
// applied per cycle with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_run_ctrl;

  typedef struct packed {
    int     n_dom;
    int     hold;
    int     stag;
    int     cyc_w;
    longint maxc;
  } cfg_t;

  // status: 0 sequencing, 1 running, 2 done, 3 timed out
  typedef struct packed {
    int          c;
    int          st;
    logic [7:0]  dom;
    logic        rdy;
    logic        done;
    logic        tmo;
    logic [63:0] cnt;
  } mdl_t;

  localparam cfg_t CA = '{n_dom: 2, hold: 25, stag: 4, cyc_w: 32, maxc: 30000000};
  localparam cfg_t CB = '{n_dom: 3, hold: 3,  stag: 2, cyc_w: 16, maxc: 10};
  localparam cfg_t CC = '{n_dom: 1, hold: 1,  stag: 1, cyc_w: 4,  maxc: 0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ext = 1'b0;
  logic pau = 1'b0;
  logic hlt = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  mdl_t ma, mb, mc;

  always #5 clk = ~clk;

  run_ctrl_if #(.N_DOM(2), .CYC_W(32)) ifa ();
  run_ctrl_if #(.N_DOM(3), .CYC_W(16)) ifb ();
  run_ctrl_if #(.N_DOM(1), .CYC_W(4))  ifc ();

  assign ifa.ext_rst_req = ext;
  assign ifa.pause_in    = pau;
  assign ifa.halt_in     = hlt;
  assign ifb.ext_rst_req = ext;
  assign ifb.pause_in    = pau;
  assign ifb.halt_in     = hlt;
  assign ifc.ext_rst_req = ext;
  assign ifc.pause_in    = pau;
  assign ifc.halt_in     = hlt;

  run_ctrl #(.N_DOM(2), .HOLD(25), .STAGGER(4), .CYC_W(32), .MAX_CYCLES(30000000))
    u_a (.clk_in(clk), .rst_in(rst), .bus(ifa));
  run_ctrl #(.N_DOM(3), .HOLD(3), .STAGGER(2), .CYC_W(16), .MAX_CYCLES(10))
    u_b (.clk_in(clk), .rst_in(rst), .bus(ifb));
  run_ctrl #(.N_DOM(1), .HOLD(1), .STAGGER(1), .CYC_W(4), .MAX_CYCLES(0))
    u_c (.clk_in(clk), .rst_in(rst), .bus(ifc));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mstep(input mdl_t m, input cfg_t k, input logic rn,
                                 input logic e, input logic p, input logic h);
    mdl_t        r;
    logic        hit;
    logic [63:0] sat;
    r   = m;
    sat = (64'd1 << k.cyc_w) - 64'd1;
    if (!rn || e) begin
      r.c    = 0;
      r.st   = 0;
      r.dom  = 8'((16'd1 << k.n_dom) - 16'd1);
      r.rdy  = 1'b0;
      r.done = 1'b0;
      r.tmo  = 1'b0;
      r.cnt  = 64'd0;
    end else if (m.st == 0) begin
      for (int i = 0; i < k.n_dom; i++) r.dom[i] = (m.c < k.hold + i * k.stag);
      if (m.c == k.hold + (k.n_dom - 1) * k.stag) r.st = 1;
      r.c = m.c + 1;
    end else if (m.st == 1) begin
      hit = (k.maxc != 0) && m.rdy && (m.cnt == 64'(k.maxc - 1));
      if (m.rdy && m.cnt < sat) r.cnt = m.cnt + 64'd1;
      if (h) begin
        r.st = 2; r.done = 1'b1; r.rdy = 1'b0;
      end else if (hit) begin
        r.st = 3; r.tmo = 1'b1; r.rdy = 1'b0;
      end else begin
        r.rdy = !p;
      end
    end
    return r;
  endfunction

  task automatic cmp(input string nm, input mdl_t m, input cfg_t k, input logic [7:0] dom,
                     input logic rdy, input logic done, input logic tmo, input logic [63:0] cnt);
    logic [7:0] mask;
    mask = 8'((16'd1 << k.n_dom) - 16'd1);
    chk({nm, ".dom"},  64'(dom & mask), 64'(m.dom & mask));
    chk({nm, ".rdy"},  64'(rdy),  64'(m.rdy));
    chk({nm, ".done"}, 64'(done), 64'(m.done));
    chk({nm, ".tmo"},  64'(tmo),  64'(m.tmo));
    chk({nm, ".cnt"},  cnt, m.cnt);
  endtask

  // One clock edge: advance the models with the inputs that edge sampled and
  // compare every output of every instance.
  task automatic tick();
    @(posedge clk);
    #1;
    ma = mstep(ma, CA, rst, ext, pau, hlt);
    mb = mstep(mb, CB, rst, ext, pau, hlt);
    mc = mstep(mc, CC, rst, ext, pau, hlt);
    cmp("A", ma, CA, 8'(ifa.dom_rst_out), ifa.rdy_out, ifa.done_out, ifa.timeout_out,
        64'(ifa.cycle_cnt_out));
    cmp("B", mb, CB, 8'(ifb.dom_rst_out), ifb.rdy_out, ifb.done_out, ifb.timeout_out,
        64'(ifb.cycle_cnt_out));
    cmp("C", mc, CC, 8'(ifc.dom_rst_out), ifc.rdy_out, ifc.done_out, ifc.timeout_out,
        64'(ifc.cycle_cnt_out));
  endtask

  task automatic restart();
    ext = 1'b1;
    tick();
    ext = 1'b0;
  endtask

  initial begin
    int lo_cnt;
    int hold_len;
    bit seen_rel;

    // Reset held low for a few edges.
    rst = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("A.dom@rst", 64'(ifa.dom_rst_out), 64'd3);
    chk("B.dom@rst", 64'(ifb.dom_rst_out), 64'd7);

    // Power-up timeline with a 3-cycle pause once A is running.
    rst    = 1'b1;
    lo_cnt = 0;
    for (int k = 0; k < 46; k++) begin
      pau = (k >= 41 && k <= 43);
      tick();
      if (k == 24) chk("A.dom@24", 64'(ifa.dom_rst_out), 64'd3);
      if (k == 25) chk("A.dom@25", 64'(ifa.dom_rst_out), 64'd2);
      if (k == 28) chk("A.dom@28", 64'(ifa.dom_rst_out), 64'd2);
      if (k == 29) begin
        chk("A.dom@29", 64'(ifa.dom_rst_out), 64'd0);
        chk("A.rdy@29", 64'(ifa.rdy_out), 64'd0);
      end
      if (k == 30) chk("A.rdy@30", 64'(ifa.rdy_out), 64'd1);
      if (k >= 41 && !ifa.rdy_out) lo_cnt++;
      if (k == 44) chk("A.cnt@44", 64'(ifa.cycle_cnt_out), 64'd11);
    end
    pau = 1'b0;
    chk("A.pause_len", 64'(lo_cnt), 64'd3);
    chk("B.tmo",       64'(ifb.timeout_out), 64'd1);
    chk("B.rdy",       64'(ifb.rdy_out), 64'd0);
    chk("B.cnt",       64'(ifb.cycle_cnt_out), 64'd10);
    chk("C.cnt_sat",   64'(ifc.cycle_cnt_out), 64'd15);
    chk("C.tmo",       64'(ifc.timeout_out), 64'd0);

    // Restart during RELEASE after domain 0 of A has been released.
    restart();
    for (int k = 0; k < 26; k++) tick();
    chk("A.dom_rel0", 64'(ifa.dom_rst_out), 64'd2);
    restart();
    chk("A.dom_restart", 64'(ifa.dom_rst_out), 64'd3);
    hold_len = 0;
    seen_rel = 1'b0;
    for (int k = 0; k < 100 && !seen_rel; k++) begin
      tick();
      if (ifa.dom_rst_out == 2'b11) hold_len++;
      else seen_rel = 1'b1;
    end
    chk("A.rehold_len", 64'(hold_len), 64'd25);

    // Halt on the very cycle B's watchdog expires: completion wins.
    restart();
    for (int k = 0; k < 21; k++) begin
      hlt = (k == 18);
      tick();
      if (k == 18) begin
        chk("B.done@exp", 64'(ifb.done_out), 64'd1);
        chk("B.tmo@exp",  64'(ifb.timeout_out), 64'd0);
        chk("B.cnt@exp",  64'(ifb.cycle_cnt_out), 64'd10);
      end
    end
    hlt = 1'b0;

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 399) != 0);
      ext = ($urandom_range(0, 149) == 0);
      hlt = ($urandom_range(0, 79) == 0);
      pau = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
